register_file_1r_1w_ctrl: RTL and testbench



---
 rtl/register_file_1r_1w_ctrl_if.sv | 45 ++++
 rtl/register_file_1r_1w_ctrl.sv | 134 +++++++++++++
 tb/tb_register_file_1r_1w_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_1r_1w_ctrl_if.sv
// Bundle of the write, read-request, read-response and register-file port signals.
// Latency: none, wires only.
// Backpressure: valid/ready on write and read-request streams, ready on the response stream.
interface register_file_1r_1w_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH / 8
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_BYTE-1:0]   wr_be;
   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [ADDR_WIDTH-1:0] rd_req_addr;
   logic                  rd_rsp_valid;
   logic                  rd_rsp_ready;
   logic [DATA_WIDTH-1:0] rd_rsp_data;
   logic                  rf_write_en;
   logic [ADDR_WIDTH-1:0] rf_write_addr;
   logic [DATA_WIDTH-1:0] rf_write_data;
   logic [NUM_BYTE-1:0]   rf_write_be;
   logic                  rf_read_en;
   logic [ADDR_WIDTH-1:0] rf_read_addr;
   logic [DATA_WIDTH-1:0] rf_read_data;

   // Controller side
   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_be,
      input  rd_req_valid, rd_req_addr, rd_rsp_ready, rf_read_data,
      output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
      output rf_write_en, rf_write_addr, rf_write_data, rf_write_be,
      output rf_read_en, rf_read_addr
   );

   // Requester and register-file side
   modport master (
      output wr_valid, wr_addr, wr_data, wr_be,
      output rd_req_valid, rd_req_addr, rd_rsp_ready, rf_read_data,
      input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
      input  rf_write_en, rf_write_addr, rf_write_data, rf_write_be,
      input  rf_read_en, rf_read_addr
   );
endinterface

// File: rtl/register_file_1r_1w_ctrl.sv
// Request-side controller for a latch-based 1R/1W register file with in-order read responses.
// Latency: write reaches the array port 1 cycle after accept; read response 3 cycles after accept.
// Backpressure: writes never stalled outside reset; reads stall on RAW hazard or when RSP_DEPTH credits are used.
module register_file_1r_1w_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH / 8,
   parameter int RSP_DEPTH  = 4
) (
   input logic                      clk,
   input logic                      rst,
   register_file_1r_1w_ctrl_if.slave bus
);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int OUT_W = CNT_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [OUT_W-1:0] out_t;

   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [NUM_BYTE-1:0]   wr_be_q, wr_be_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  s2_vld_q, s2_vld_d;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
   ptr_t                  wptr_q, wptr_d, rptr_q, rptr_d;
   cnt_t                  cnt_q, cnt_d;

   logic wr_rdy, wr_fire, rd_rdy, rd_fire, hazard, credit_ok, rsp_vld, push, pop;
   out_t outstanding;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(RSP_DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Handshakes: a read may not pass a write to the same address that has not yet landed in the array,
   // and every read in S1, S2 or the FIFO holds one response slot until it is popped.
   always_comb begin
      wr_rdy      = !rst;
      wr_fire     = bus.wr_valid & wr_rdy;
      hazard      = (wr_fire & (bus.wr_addr == bus.rd_req_addr)) |
                    (wr_en_q & (wr_addr_q == bus.rd_req_addr));
      outstanding = out_t'(cnt_q) + out_t'(rd_en_q) + out_t'(s2_vld_q);
      credit_ok   = outstanding < out_t'(RSP_DEPTH);
      rd_rdy      = !rst & credit_ok & !hazard;
      rd_fire     = bus.rd_req_valid & rd_rdy;
      rsp_vld     = (cnt_q != '0) & !rst;
      push        = s2_vld_q;
      pop         = rsp_vld & bus.rd_rsp_ready;
   end

   // Next state of the write stage, both read stages and the response FIFO
   always_comb begin
      wr_en_d   = wr_fire;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_be_d   = wr_be_q;
      rd_en_d   = rd_fire;
      rd_addr_d = rd_addr_q;
      s2_vld_d  = rd_en_q;
      fifo_d    = fifo_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      if (wr_fire) begin
         wr_addr_d = bus.wr_addr;
         wr_data_d = bus.wr_data;
         wr_be_d   = bus.wr_be;
      end
      if (rd_fire) begin
         rd_addr_d = bus.rd_req_addr;
      end
      if (push) begin
         fifo_d[wptr_q] = bus.rf_read_data;
         wptr_d         = ptr_inc(wptr_q);
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + cnt_t'(1);
         2'b01:   cnt_d = cnt_q - cnt_t'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; reset drops every in-flight read so none of them produces a response
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_be_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         s2_vld_q  <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_be_q   <= wr_be_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         s2_vld_q  <= s2_vld_d;
         fifo_q    <= fifo_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.wr_ready      = wr_rdy;
   assign bus.rd_req_ready  = rd_rdy;
   assign bus.rd_rsp_valid  = rsp_vld;
   assign bus.rd_rsp_data   = fifo_q[rptr_q];
   // A write accepted just before reset still completes; a read in S1 is dropped, so its enable is masked.
   assign bus.rf_write_en   = wr_en_q;
   assign bus.rf_write_addr = wr_addr_q;
   assign bus.rf_write_data = wr_data_q;
   assign bus.rf_write_be   = wr_be_q;
   assign bus.rf_read_en    = rd_en_q & !rst;
   assign bus.rf_read_addr  = rd_addr_q;
endmodule

// File: tb/tb_register_file_1r_1w_ctrl.sv
// Bench for register_file_1r_1w_ctrl: directed stimulus, latch register-file model, reference model.
// Latency: responses checked at exactly 3 cycles after accept while the response side is never stalled.
// Backpressure: exercises RAW stalls, credit exhaustion and reset with reads in flight.
module tb_register_file_1r_1w_ctrl;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NB    = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   register_file_1r_1w_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) bus ();

   register_file_1r_1w_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .RSP_DEPTH(DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int npops = 0;
   bit mon_on = 1'b0;
   bit strict = 1'b1;

   typedef struct {
      logic [DW-1:0] data;
      int            acc;
   } exp_t;
   exp_t expq[$];

   logic [DW-1:0] gmem [32];
   logic [DW-1:0] rfm  [32];

   logic          pw_vld = 1'b0;
   logic [AW-1:0] pw_addr;
   logic [DW-1:0] pw_data;
   logic [NB-1:0] pw_be;
   logic          pr_vld = 1'b0;
   logic [AW-1:0] pr_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Register file array: write lands in the cycle after rf_write_en, read data appears the cycle after rf_read_en
   initial begin
      logic          cwe, cre;
      logic [AW-1:0] cwa, cra;
      logic [DW-1:0] cwd;
      logic [NB-1:0] cwb;
      for (int i = 0; i < 32; i++) rfm[i] = '0;
      bus.rf_read_data = '0;
      forever begin
         @(negedge clk);
         cwe = bus.rf_write_en;   cwa = bus.rf_write_addr;
         cwd = bus.rf_write_data; cwb = bus.rf_write_be;
         cre = bus.rf_read_en;    cra = bus.rf_read_addr;
         @(posedge clk);
         #1;
         if (cre === 1'b1) bus.rf_read_data = rfm[cra];
         if (cwe === 1'b1)
            for (int b = 0; b < NB; b++)
               if (cwb[b]) rfm[cwa][8*b +: 8] = cwd[8*b +: 8];
      end
   end

   // Reference model: memory updated at write accept, reads snapshot it at accept, responses in accept order
   always @(negedge clk) begin
      if (mon_on) begin
         if (rst) begin
            chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
            chk("rst_rf_read_en", bus.rf_read_en, 0);
            chk("rst_wr_ready", bus.wr_ready, 0);
            chk("rst_rd_req_ready", bus.rd_req_ready, 0);
            expq.delete();
         end
         chk("rf_write_en", bus.rf_write_en, pw_vld);
         if (pw_vld) begin
            chk("rf_write_addr", bus.rf_write_addr, pw_addr);
            chk("rf_write_data", bus.rf_write_data, pw_data);
            chk("rf_write_be", bus.rf_write_be, pw_be);
         end
         chk("rf_read_en", bus.rf_read_en, pr_vld && !rst);
         if (pr_vld && !rst) chk("rf_read_addr", bus.rf_read_addr, pr_addr);
         if (expq.size() >= DEPTH) chk("credit_block", bus.rd_req_ready, 0);
         if (bus.rd_rsp_valid && bus.rd_rsp_ready) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_rsp: got a response, required none (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("rsp_data", bus.rd_rsp_data, e.data);
               if (strict) chk("rsp_latency", cyc - e.acc, 3);
               npops++;
            end
         end
         pw_vld = bus.wr_valid && bus.wr_ready;
         if (pw_vld) begin
            pw_addr = bus.wr_addr;
            pw_data = bus.wr_data;
            pw_be   = bus.wr_be;
            for (int b = 0; b < NB; b++)
               if (pw_be[b]) gmem[pw_addr][8*b +: 8] = pw_data[8*b +: 8];
         end
         pr_vld = bus.rd_req_valid && bus.rd_req_ready;
         if (pr_vld) begin
            pr_addr = bus.rd_req_addr;
            expq.push_back('{data: gmem[pr_addr], acc: cyc});
         end
      end
   end

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      bit got;
      bus.rd_req_addr  = a;
      bus.rd_req_valid = 1'b1;
      bus.rd_rsp_ready = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (bus.rd_req_ready) got = 1'b1;
         step();
      end
      bus.rd_req_valid = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL rd_accept_timeout: got no accept, required accept within 20 cycles");
      end
      got = 1'b0;
      d   = 'x;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (bus.rd_rsp_valid) begin
            got = 1'b1;
            d   = bus.rd_rsp_data;
         end
         step();
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL rd_rsp_timeout: got no response, required one within 20 cycles");
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got no completion, required end before 50000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      int acc, p0;
      for (int i = 0; i < 32; i++) gmem[i] = '0;

      // Reset held 3 cycles with every valid asserted
      rst = 1'b1;
      bus.wr_valid = 1'b1;     bus.wr_addr = 5'd1;  bus.wr_data = 32'h12345678; bus.wr_be = 4'hF;
      bus.rd_req_valid = 1'b1; bus.rd_req_addr = 5'd2;
      bus.rd_rsp_ready = 1'b1;
      step();
      mon_on = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("reset_wr_ready", bus.wr_ready, 0);
         chk("reset_rd_req_ready", bus.rd_req_ready, 0);
         chk("reset_rf_write_en", bus.rf_write_en, 0);
         chk("reset_rf_write_addr", bus.rf_write_addr, 0);
         chk("reset_rf_write_data", bus.rf_write_data, 0);
         chk("reset_rf_write_be", bus.rf_write_be, 0);
         chk("reset_rf_read_en", bus.rf_read_en, 0);
         chk("reset_rf_read_addr", bus.rf_read_addr, 0);
         step();
      end
      rst = 1'b0;
      bus.wr_valid = 1'b0;
      bus.rd_req_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_wr_ready", bus.wr_ready, 1);
      chk("post_reset_rf_write_en", bus.rf_write_en, 0);
      chk("post_reset_rsp_valid", bus.rd_rsp_valid, 0);
      step();

      // Back-to-back RAW on address 5
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF; bus.wr_be = 4'hF;
      bus.rd_req_valid = 1'b1; bus.rd_req_addr = 5'd5;
      @(negedge clk); chk("raw_stall_n", bus.rd_req_ready, 0);
      step(); bus.wr_valid = 1'b0;
      @(negedge clk); chk("raw_stall_n1", bus.rd_req_ready, 0);
      step();
      @(negedge clk); chk("raw_accept_n2", bus.rd_req_ready, 1);
      step(); bus.rd_req_valid = 1'b0;
      @(negedge clk); chk("raw_no_rsp_n3", bus.rd_rsp_valid, 0);
      step();
      @(negedge clk); chk("raw_no_rsp_n4", bus.rd_rsp_valid, 0);
      step();
      @(negedge clk);
      chk("raw_rsp_valid_n5", bus.rd_rsp_valid, 1);
      chk("raw_rsp_data_n5", bus.rd_rsp_data, 32'hDEADBEEF);
      step();

      // Byte-enable merge on address 3
      bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h11223344; bus.wr_be = 4'hF;
      step();
      bus.wr_data = 32'hAABBCCDD; bus.wr_be = 4'h5;
      step();
      bus.wr_valid = 1'b0;
      step();
      do_read(5'd3, d);
      chk("byte_merge", d, 32'h11BB33DD);

      // Preload 0..15, then stream 16 reads at one per cycle
      for (int i = 0; i < 16; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = AW'(i);
         bus.wr_data  = {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
         bus.wr_be    = 4'hF;
         @(negedge clk); chk("preload_wr_ready", bus.wr_ready, 1);
         step();
      end
      bus.wr_valid = 1'b0;
      step(); step();
      p0 = npops;
      for (int i = 0; i < 16; i++) begin
         bus.rd_req_valid = 1'b1;
         bus.rd_req_addr  = AW'(i);
         @(negedge clk); chk("stream_accept", bus.rd_req_ready, 1);
         step();
      end
      bus.rd_req_valid = 1'b0;
      repeat (6) step();
      chk("stream_pops", npops - p0, 16);

      // Credit exhaustion with the response side stalled
      strict = 1'b0;
      bus.rd_rsp_ready = 1'b0;
      acc = 0;
      p0  = npops;
      for (int k = 0; k < 8; k++) begin
         bus.rd_req_valid = 1'b1;
         bus.rd_req_addr  = AW'(8 + acc);
         @(negedge clk);
         if (bus.rd_req_ready) acc++;
         step();
      end
      bus.rd_req_addr = AW'(8 + acc);
      chk("bp_accepts", acc, 4);
      @(negedge clk);
      chk("bp_blocked", bus.rd_req_ready, 0);
      chk("bp_rsp_valid", bus.rd_rsp_valid, 1);
      step();
      bus.rd_rsp_ready = 1'b1;
      @(negedge clk); chk("bp_pop_cycle_blocked", bus.rd_req_ready, 0);
      step();
      @(negedge clk); chk("bp_resume", bus.rd_req_ready, 1);
      step();
      bus.rd_req_valid = 1'b0;
      repeat (8) step();
      chk("bp_pops", npops - p0, 5);

      // Reset with reads in S1, S2 and the FIFO
      bus.rd_rsp_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus.rd_req_valid = 1'b1;
         bus.rd_req_addr  = AW'(i);
         @(negedge clk); chk("mid_issue", bus.rd_req_ready, 1);
         step();
      end
      bus.rd_req_valid = 1'b0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      bus.rd_rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); chk("post_rst_no_rsp", bus.rd_rsp_valid, 0);
         step();
      end
      bus.rd_rsp_ready = 1'b0;
      acc = 0;
      p0  = npops;
      for (int k = 0; k < 8; k++) begin
         bus.rd_req_valid = 1'b1;
         bus.rd_req_addr  = AW'(4 + acc);
         @(negedge clk);
         if (bus.rd_req_ready) acc++;
         step();
      end
      bus.rd_req_valid = 1'b0;
      chk("post_rst_credits", acc, 4);
      bus.rd_rsp_ready = 1'b1;
      repeat (8) step();
      chk("post_rst_pops", npops - p0, 4);
      chk("queue_drained", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
